// File: rtl/racing_game_pkg.sv
// Shared constants and types for the racing game video pipeline.
// Timing constants follow a 640x480 raster with 800 clocks per line.
package racing_game_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    LOAD  = 2'd2,
    FLUSH = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sprite_rr_picker.sv
// Rotating-priority encoder: returns the first set pending bit at or after
// rr_ptr, wrapping modulo NUM_SPRITES (non-power-of-two counts are legal).
module sprite_rr_picker #(
  parameter int NUM_SPRITES = 4,
  parameter int SEL_W       = $clog2(NUM_SPRITES)
) (
  input  logic [NUM_SPRITES-1:0] pending,
  input  logic [SEL_W-1:0]       rr_ptr,
  output logic                   hit,
  output logic [SEL_W-1:0]       idx
);

  logic [SEL_W:0] cand;

  // Walk from farthest to nearest so the candidate closest to rr_ptr wins.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (SEL_W+1)'(i);
      if (cand >= (SEL_W+1)'(NUM_SPRITES))
        cand = cand - (SEL_W+1)'(NUM_SPRITES);
      if (pending[cand[SEL_W-1:0]]) begin
        hit = 1'b1;
        idx = cand[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sprite_rom_scheduler.sv
// Shares the single car sprite ROM among the sprite renderers during
// horizontal blanking, one SLOT_CYCLES load window per requester per line.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for hpos==HBLANK_START; samples req there
//   SCAN  | one clock: pick next pending renderer from rr_ptr onwards
//   LOAD  | load strobe held for SLOT_CYCLES clocks on the granted one
//   FLUSH | one clock: publish starved/overrun, clear pending, drop busy
module sprite_rom_scheduler #(
  parameter int NUM_SPRITES  = 4,
  parameter int SLOT_CYCLES  = 4,
  parameter int HBLANK_START = racing_game_pkg::H_VISIBLE,
  parameter int H_TOTAL      = racing_game_pkg::H_TOTAL,
  parameter int SEL_W        = $clog2(NUM_SPRITES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             hpos,
  input  logic [NUM_SPRITES-1:0] req,
  output logic [NUM_SPRITES-1:0] load,
  output logic [SEL_W-1:0]       sel,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_SPRITES-1:0] starved,
  output logic                   overrun
);

  import racing_game_pkg::*;

  localparam int               CNT_W     = $clog2(SLOT_CYCLES + 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(NUM_SPRITES - 1);

  sched_state_t           state, state_nxt;
  logic [NUM_SPRITES-1:0] pending, pending_nxt;
  logic [SEL_W-1:0]       rr_ptr, rr_nxt;
  logic [SEL_W-1:0]       grant, grant_nxt;
  logic [CNT_W-1:0]       slot_cnt, cnt_nxt;
  logic [NUM_SPRITES-1:0] load_nxt;
  logic [SEL_W-1:0]       sel_nxt;
  logic                   busy_nxt;
  logic                   done_nxt;
  logic [NUM_SPRITES-1:0] starved_nxt;
  logic                   overrun_nxt;

  logic                   pick_hit;
  logic [SEL_W-1:0]       pick_idx;
  logic                   win_open;
  logic                   win_close;

  assign win_open  = (hpos == 10'(HBLANK_START));
  assign win_close = (hpos == 10'(H_TOTAL - 1));

  sprite_rr_picker #(
    .NUM_SPRITES (NUM_SPRITES),
    .SEL_W       (SEL_W)
  ) u_picker (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .hit     (pick_hit),
    .idx     (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pending  <= '0;
      rr_ptr   <= '0;
      grant    <= '0;
      slot_cnt <= '0;
      load     <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      starved  <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      rr_ptr   <= rr_nxt;
      grant    <= grant_nxt;
      slot_cnt <= cnt_nxt;
      load     <= load_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      starved  <= starved_nxt;
      overrun  <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    rr_nxt      = rr_ptr;
    grant_nxt   = grant;
    cnt_nxt     = slot_cnt;
    load_nxt    = load;
    sel_nxt     = sel;
    busy_nxt    = busy;
    starved_nxt = starved;
    overrun_nxt = overrun;

    case (state)
      IDLE: begin
        if (win_open) begin
          pending_nxt = req;
          busy_nxt    = 1'b1;
          state_nxt   = SCAN;
        end
      end

      SCAN: begin
        // A reopen seen here means H_TOTAL is misconfigured; treat it as a close.
        if (win_close || win_open) begin
          state_nxt = FLUSH;
        end else if (pick_hit) begin
          grant_nxt          = pick_idx;
          sel_nxt            = pick_idx;
          cnt_nxt            = '0;
          load_nxt           = '0;
          load_nxt[pick_idx] = 1'b1;
          state_nxt          = LOAD;
        end else begin
          state_nxt = FLUSH;
        end
      end

      LOAD: begin
        if (slot_cnt == SLOT_LAST) begin
          pending_nxt[grant] = 1'b0;
          rr_nxt             = (grant == IDX_LAST) ? '0 : grant + SEL_W'(1);
          load_nxt           = '0;
          state_nxt          = (win_close || win_open) ? FLUSH : SCAN;
        end else if (win_close || win_open) begin
          // Cut short: pending bit and rr_ptr stay, so this renderer leads next line.
          load_nxt  = '0;
          state_nxt = FLUSH;
        end else begin
          cnt_nxt = slot_cnt + CNT_W'(1);
        end
      end

      FLUSH: begin
        starved_nxt = pending;
        overrun_nxt = overrun | (|pending);
        pending_nxt = '0;
        busy_nxt    = 1'b0;
        state_nxt   = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    done_nxt = (state != FLUSH) && (state_nxt == FLUSH) && (pending_nxt == '0);
  end

endmodule
